// File: rtl/freq_ratio_meter_pkg.sv
// Shared types and constants for the frequency/duty meter.
package freq_meas_pkg;
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int SYNC_DEPTH = 2;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/freq_ratio_meter_if.sv
// Control and result bundle between the meter and its user.
interface freq_ratio_meter_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             overflow;

  modport master (
    output en, sig_in,
    input  period, high_time, meas_valid, locked, overflow
  );

  modport slave (
    input  en, sig_in,
    output period, high_time, meas_valid, locked, overflow
  );
endinterface

// File: rtl/freq_ratio_meter_sync_rise_det.sv
// Brings the asynchronous input into clk and flags its rising edge.
module sync_rise_det
  import freq_meas_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s2,
  output logic rise
);
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic                  s3_q, s3_d;

  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], d};
    s3_d   = sync_q[SYNC_DEPTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s3_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s3_q   <= s3_d;
    end
  end

  assign s2   = sync_q[SYNC_DEPTH-1];
  assign rise = s2 & ~s3_q;
endmodule

// File: rtl/freq_ratio_meter.sv
// Measures period and high time of a slow input in clk cycles and flags lock.
// state   | meaning
// IDLE    | waiting for an arming rise (or disabled / after overflow)
// MEASURE | counting cycles since the last rise
module freq_ratio_meter
  import freq_meas_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  freq_ratio_meter_if.slave bus
);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CNT);

  logic s2, rise;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0]   period_q, period_d, high_time_q, high_time_d;
  logic [MATCH_W-1:0] match_q, match_d, match_nxt;
  logic               meas_valid_q, meas_valid_d;
  logic               locked_q, locked_d, overflow_q, overflow_d;

  sync_rise_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.sig_in),
    .s2   (s2),
    .rise (rise)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    match_d      = match_q;
    match_nxt    = '0;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    overflow_d   = overflow_q;

    if (!bus.en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      match_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end
        end
        MEASURE: begin
          // A rise beats saturation: the count is still a valid period.
          if (rise) begin
            period_d     = cnt_q;
            high_time_d  = hcnt_q;
            meas_valid_d = 1'b1;
            overflow_d   = 1'b0;
            cnt_d        = CNT_ONE;
            hcnt_d       = CNT_ONE;
            if (match_q == '0)
              match_nxt = MATCH_ONE;
            else if (cnt_q == period_q)
              match_nxt = (match_q == MATCH_FULL) ? match_q : match_q + MATCH_ONE;
            else
              match_nxt = MATCH_ONE;
            match_d  = match_nxt;
            locked_d = (match_nxt == MATCH_FULL);
          end else if (cnt_q == CNT_MAX) begin
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            match_d    = '0;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (s2) hcnt_d = hcnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      match_q      <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      match_q      <= match_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_time_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_freq_ratio_meter.sv
// Directed bench for freq_ratio_meter: 8-bit instance for lock/enable/reset, 4-bit for overflow.
module tb_freq_ratio_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  freq_ratio_meter_if #(.CNT_W(8)) ifc8 ();
  freq_ratio_meter_if #(.CNT_W(4)) ifc4 ();

  freq_ratio_meter #(.CNT_W(8), .LOCK_CNT(4)) dut8 (.clk(clk), .rst(rst), .bus(ifc8));
  freq_ratio_meter #(.CNT_W(4), .LOCK_CNT(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));

  typedef struct {
    int   period;
    int   high;
    logic locked;
    int   cyc;
  } rec_t;

  rec_t q8[$];
  rec_t q4[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    if (ifc8.meas_valid === 1'b1)
      q8.push_back('{int'(ifc8.period), int'(ifc8.high_time), ifc8.locked, cycle_cnt});
    if (ifc4.meas_valid === 1'b1)
      q4.push_back('{int'(ifc4.period), int'(ifc4.high_time), ifc4.locked, cycle_cnt});
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_wave(input bit sel4, input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      if (sel4) ifc4.sig_in = 1'b1; else ifc8.sig_in = 1'b1;
      cyc(hi);
      if (sel4) ifc4.sig_in = 1'b0; else ifc8.sig_in = 1'b0;
      cyc(lo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc8.en = 1'b0; ifc8.sig_in = 1'b0;
    ifc4.en = 1'b0; ifc4.sig_in = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    checks++; if (ifc8.period !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", ifc8.period); end
    checks++; if (ifc8.high_time !== 8'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", ifc8.high_time); end
    checks++; if (ifc8.meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifc8.meas_valid); end
    checks++; if (ifc8.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", ifc8.locked); end
    checks++; if (ifc8.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ifc8.overflow); end
    checks++; if (ifc4.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow4: got %b want 0", ifc4.overflow); end
  endtask

  task automatic test_div3();
    int n0;
    ifc8.en = 1'b1;
    q8.delete();
    n0 = cycle_cnt;
    drive_wave(1'b0, 1, 2, 8);
    cyc(3);
    checks++; if (q8.size() != 7) begin errors++; $display("FAIL div3_count: got %0d want 7", q8.size()); end
    checks++; if (q8[0].cyc != n0 + 6) begin errors++; $display("FAIL div3_first_latency: got cycle %0d want %0d", q8[0].cyc, n0 + 6); end
    checks++; if (q8[0].period != 3) begin errors++; $display("FAIL div3_period: got %0d want 3", q8[0].period); end
    checks++; if (q8[0].high != 1) begin errors++; $display("FAIL div3_high: got %0d want 1", q8[0].high); end
    checks++; if (q8[2].locked !== 1'b0) begin errors++; $display("FAIL div3_lock_early: got %b want 0", q8[2].locked); end
    checks++; if (q8[3].locked !== 1'b1) begin errors++; $display("FAIL div3_lock_4th: got %b want 1", q8[3].locked); end
  endtask

  task automatic test_period_change();
    ifc8.en = 1'b0;
    cyc(3);
    ifc8.en = 1'b1;
    q8.delete();
    drive_wave(1'b0, 5, 5, 6);
    drive_wave(1'b0, 6, 6, 5);
    cyc(3);
    checks++; if (q8.size() != 10) begin errors++; $display("FAIL chg_count: got %0d want 10", q8.size()); end
    checks++; if (q8[0].period != 10 || q8[0].high != 5) begin errors++; $display("FAIL chg_p10: got %0d/%0d want 10/5", q8[0].period, q8[0].high); end
    checks++; if (q8[2].locked !== 1'b0) begin errors++; $display("FAIL chg_p10_early: got %b want 0", q8[2].locked); end
    checks++; if (q8[3].locked !== 1'b1) begin errors++; $display("FAIL chg_p10_lock: got %b want 1", q8[3].locked); end
    checks++; if (q8[5].period != 10 || q8[5].locked !== 1'b1) begin errors++; $display("FAIL chg_last10: got %0d/%b want 10/1", q8[5].period, q8[5].locked); end
    checks++; if (q8[6].period != 12 || q8[6].high != 6) begin errors++; $display("FAIL chg_p12: got %0d/%0d want 12/6", q8[6].period, q8[6].high); end
    checks++; if (q8[6].locked !== 1'b0) begin errors++; $display("FAIL chg_unlock: got %b want 0", q8[6].locked); end
    checks++; if (q8[8].locked !== 1'b0) begin errors++; $display("FAIL chg_p12_early: got %b want 0", q8[8].locked); end
    checks++; if (q8[9].locked !== 1'b1) begin errors++; $display("FAIL chg_p12_relock: got %b want 1", q8[9].locked); end
  endtask

  task automatic test_en_drop();
    checks++; if (ifc8.locked !== 1'b1) begin errors++; $display("FAIL en_pre_locked: got %b want 1", ifc8.locked); end
    ifc8.en = 1'b0;
    cyc(1);
    checks++; if (ifc8.locked !== 1'b0) begin errors++; $display("FAIL en_unlock: got %b want 0", ifc8.locked); end
    checks++; if (ifc8.period !== 8'd12 || ifc8.high_time !== 8'd6) begin errors++; $display("FAIL en_hold: got %0d/%0d want 12/6", ifc8.period, ifc8.high_time); end
    cyc(2);
    ifc8.en = 1'b1;
    q8.delete();
    drive_wave(1'b0, 6, 6, 2);
    cyc(3);
    checks++; if (q8.size() != 1) begin errors++; $display("FAIL en_arm_only: got %0d results want 1", q8.size()); end
    checks++; if (q8[0].period != 12 || q8[0].locked !== 1'b0) begin errors++; $display("FAIL en_remeasure: got %0d/%b want 12/0", q8[0].period, q8[0].locked); end
  endtask

  task automatic test_reset_mid();
    int n0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    checks++; if (ifc8.period !== 8'd0 || ifc8.high_time !== 8'd0) begin errors++; $display("FAIL rst_mid_vals: got %0d/%0d want 0/0", ifc8.period, ifc8.high_time); end
    checks++; if ({ifc8.meas_valid, ifc8.locked, ifc8.overflow} !== 3'b000) begin errors++; $display("FAIL rst_mid_flags: got %b want 000", {ifc8.meas_valid, ifc8.locked, ifc8.overflow}); end
    rst = 1'b0;
    q8.delete();
    n0 = cycle_cnt;
    drive_wave(1'b0, 6, 6, 3);
    cyc(3);
    checks++; if (q8.size() != 2) begin errors++; $display("FAIL rst_restart_count: got %0d want 2", q8.size()); end
    checks++; if (q8[0].period != 12 || q8[0].high != 6) begin errors++; $display("FAIL rst_restart_val: got %0d/%0d want 12/6", q8[0].period, q8[0].high); end
    checks++; if (q8[0].cyc != n0 + 15) begin errors++; $display("FAIL rst_restart_latency: got cycle %0d want %0d", q8[0].cyc, n0 + 15); end
  endtask

  task automatic test_overflow();
    ifc4.en = 1'b1;
    q4.delete();
    ifc4.sig_in = 1'b1;
    cyc(1);
    ifc4.sig_in = 1'b0;
    cyc(16);
    checks++; if (ifc4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", ifc4.overflow); end
    cyc(1);
    checks++; if (ifc4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ifc4.overflow); end
    checks++; if (ifc4.locked !== 1'b0) begin errors++; $display("FAIL ovf_locked: got %b want 0", ifc4.locked); end
    cyc(2);
    ifc4.sig_in = 1'b1;
    cyc(2);
    ifc4.sig_in = 1'b0;
    cyc(2);
    checks++; if (ifc4.overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold_on_arm: got %b want 1", ifc4.overflow); end
    cyc(1);
    drive_wave(1'b1, 2, 3, 2);
    cyc(3);
    checks++; if (q4.size() != 2) begin errors++; $display("FAIL ovf_idle_rearm: got %0d results want 2", q4.size()); end
    checks++; if (q4[0].period != 5 || q4[0].high != 2) begin errors++; $display("FAIL ovf_p5: got %0d/%0d want 5/2", q4[0].period, q4[0].high); end
    checks++; if (ifc4.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", ifc4.overflow); end
  endtask

  initial begin
    test_reset();
    test_div3();
    test_period_change();
    test_en_drop();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
